// File: rtl/disp_pkg.sv
// Shared constants and helpers for the multiplexed BCD display path.
// Defaults here match the production display; instances override them as needed.
package disp_pkg;

    localparam int BCD_W     = 4;
    localparam int MAX_NDIG  = 8;
    localparam int DEF_NDIG  = 4;
    localparam int DEF_DIV   = 1000;
    localparam int DEF_GUARD = 8;

    // Word is zero-extended to the widest supported display so one function serves every NDIG.
    function automatic logic [BCD_W-1:0] nibble_sel(
        input logic [BCD_W*MAX_NDIG-1:0] word,
        input logic [31:0]               idx
    );
        return word[idx*BCD_W +: BCD_W];
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Slot/digit counter pair for the display scanner. Exposes next-state flags so the
// parent can register its outputs in lockstep with the counters.
module scan_prescaler #(
    parameter int NDIG  = 4,
    parameter int DIV   = 1000,
    parameter int GUARD = 8,
    localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [IW-1:0] idx_d_o,
    output logic          guard_d_o,
    output logic          last_d_o,
    output logic          frame_end_o
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          wrap;

    assign wrap        = (cnt_q == CW'(DIV - 1));
    assign frame_end_o = wrap && (idx_q == IW'(NDIG - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        idx_d = idx_q;
        if (wrap) begin
            cnt_d = '0;
            idx_d = (idx_q == IW'(NDIG - 1)) ? '0 : idx_q + IW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    assign idx_d_o   = idx_d;
    assign guard_d_o = (GUARD > 0) && (cnt_d < CW'(GUARD));
    assign last_d_o  = (idx_d == IW'(NDIG - 1)) && (cnt_d == CW'(DIV - 1));

endmodule

// File: rtl/bcd_scan_mux.sv
// Time-multiplexes NDIG BCD digits onto a single-digit seven-segment decoder with
// anti-ghosting guard, leading-zero blanking and frame-aligned value updates.
module bcd_scan_mux
    import disp_pkg::*;
#(
    parameter int NDIG  = DEF_NDIG,
    parameter int DIV   = DEF_DIV,
    parameter int GUARD = DEF_GUARD
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [BCD_W*NDIG-1:0] bcd_in,
    input  logic                  lzb_en,
    output logic                  A,
    output logic                  B,
    output logic                  C,
    output logic                  D,
    output logic                  EN,
    output logic [NDIG-1:0]       DIG,
    output logic                  frame_done
);

    localparam int W  = BCD_W * NDIG;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    logic [IW-1:0] idx_d;
    logic          guard_d;
    logic          last_d;
    logic          frame_end;

    scan_prescaler #(
        .NDIG  (NDIG),
        .DIV   (DIV),
        .GUARD (GUARD)
    ) u_prescaler (
        .clk         (clk),
        .rst_n       (rst_n),
        .idx_d_o     (idx_d),
        .guard_d_o   (guard_d),
        .last_d_o    (last_d),
        .frame_end_o (frame_end)
    );

    logic [W-1:0] shadow_q, shadow_d;
    logic [W-1:0] pend_q, pend_d;
    logic         pend_v_q, pend_v_d;

    // A load coinciding with the boundary bypasses pend so it shows in the very next frame.
    always_comb begin
        shadow_d = shadow_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        if (load) begin
            pend_d   = bcd_in;
            pend_v_d = 1'b1;
        end
        if (frame_end) begin
            if (load) begin
                shadow_d = bcd_in;
            end else if (pend_v_q) begin
                shadow_d = pend_q;
            end
            pend_v_d = 1'b0;
        end
    end

    // upper_zero[i]: nibbles i..NDIG-1 of the incoming shadow are all zero.
    logic [NDIG:0]   upper_zero;
    logic [NDIG-1:0] blank;

    assign upper_zero[NDIG] = 1'b1;

    for (genvar gi = 0; gi < NDIG; gi++) begin : g_blank
        assign upper_zero[gi] = upper_zero[gi+1] && (shadow_d[gi*BCD_W +: BCD_W] == '0);
        if (gi == 0) begin : g_units
            assign blank[gi] = 1'b0;
        end else begin : g_upper
            assign blank[gi] = lzb_en && upper_zero[gi];
        end
    end

    logic [BCD_W*MAX_NDIG-1:0] shadow_ext;
    assign shadow_ext = (BCD_W*MAX_NDIG)'(shadow_d);

    logic [BCD_W-1:0] nib_q, nib_d;
    logic             en_q, en_d;
    logic [NDIG-1:0]  dig_q, dig_d;
    logic             fd_q;

    always_comb begin
        nib_d = nibble_sel(shadow_ext, 32'(idx_d));
        en_d  = 1'b0;
        dig_d = '0;
        if (!guard_d) begin
            dig_d = NDIG'(1) << idx_d;
            en_d  = !blank[idx_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            nib_q    <= '0;
            en_q     <= 1'b0;
            dig_q    <= '0;
            fd_q     <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            nib_q    <= nib_d;
            en_q     <= en_d;
            dig_q    <= dig_d;
            fd_q     <= last_d;
        end
    end

    assign A          = nib_q[3];
    assign B          = nib_q[2];
    assign C          = nib_q[1];
    assign D          = nib_q[0];
    assign EN         = en_q;
    assign DIG        = dig_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_bcd_scan_mux.sv
// Scoreboard bench for bcd_scan_mux with NDIG=4, DIV=4, GUARD=1 (16-cycle frames).
// Each scenario queues per-cycle expectations for whole frames, then drains them at negedges.
module tb_bcd_scan_mux;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] bcd_in;
    logic        lzb_en;
    logic        A, B, C, D, EN, frame_done;
    logic [3:0]  DIG;

    int vectors     = 0;
    int miscompares = 0;

    // Entry layout: {nibble[3:0], en, dig[3:0], frame_done}
    logic [9:0] sb[$];

    bcd_scan_mux #(.NDIG(4), .DIV(4), .GUARD(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .bcd_in     (bcd_in),
        .lzb_en     (lzb_en),
        .A          (A),
        .B          (B),
        .C          (C),
        .D          (D),
        .EN         (EN),
        .DIG        (DIG),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    // Expected frame: cycle 0 of each slot is guard; mask marks digits that must stay dark.
    task automatic push_frame(input logic [15:0] val, input logic [3:0] mask);
        for (int k = 0; k < 16; k++) begin
            int s;
            int c;
            logic [3:0] dg;
            s  = k / 4;
            c  = k % 4;
            dg = (c != 0) ? (4'b0001 << s) : 4'b0000;
            sb.push_back({val[s*4 +: 4], (c != 0) && !mask[s], dg, (k == 15)});
        end
    endtask

    task automatic test_reset();
        logic [9:0] act;
        rst_n = 1'b0; load = 1'b0; bcd_in = '0; lzb_en = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        act = {A, B, C, D, EN, DIG, frame_done};
        vectors++;
        if (act !== 10'b0) begin
            miscompares++;
            $display("FAIL reset_hold: got %b want %b", act, 10'b0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (EN !== 1'b1 || DIG !== 4'b0001) begin
            miscompares++;
            $display("FAIL pre_reset_slot0: got en=%b dig=%b want en=1 dig=0001", EN, DIG);
        end
        // Park a pending value, then reset before the boundary: it must be discarded.
        load = 1'b1; bcd_in = 16'h3333;
        @(negedge clk);
        load = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        act = {A, B, C, D, EN, DIG, frame_done};
        vectors++;
        if (act !== 10'b0) begin
            miscompares++;
            $display("FAIL async_reset: got %b want %b", act, 10'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset: asserted mid-slot and released");
    endtask

    task automatic test_first_frame();
        logic [9:0] exp, act;
        push_frame(16'h0000, 4'b0000);
        push_frame(16'h0000, 4'b0000);
        for (int k = 0; k < 32; k++) begin
            exp = sb.pop_front();
            act = {A, B, C, D, EN, DIG, frame_done};
            vectors++;
            if (act !== exp) begin
                miscompares++;
                $display("FAIL first_frame cyc %0d: got nib=%h en=%b dig=%b fd=%b want nib=%h en=%b dig=%b fd=%b",
                         k, act[9:6], act[5], act[4:1], act[0], exp[9:6], exp[5], exp[4:1], exp[0]);
            end
            @(negedge clk);
        end
        $display("first_frame: two zero frames scanned");
    endtask

    task automatic test_update();
        logic [9:0] exp, act;
        push_frame(16'h0000, 4'b0000);
        push_frame(16'h1234, 4'b0000);
        for (int k = 0; k < 32; k++) begin
            exp = sb.pop_front();
            act = {A, B, C, D, EN, DIG, frame_done};
            vectors++;
            if (act !== exp) begin
                miscompares++;
                $display("FAIL update cyc %0d: got nib=%h en=%b dig=%b fd=%b want nib=%h en=%b dig=%b fd=%b",
                         k, act[9:6], act[5], act[4:1], act[0], exp[9:6], exp[5], exp[4:1], exp[0]);
            end
            load = (k == 8); bcd_in = 16'h1234;
            if (load) $display("update: load 1234 in slot 2");
            @(negedge clk);
        end
    endtask

    task automatic test_lzb();
        logic [9:0] exp, act;
        lzb_en = 1'b1;
        push_frame(16'h1234, 4'b0000);
        push_frame(16'h0070, 4'b1100);
        push_frame(16'h0000, 4'b1110);
        for (int k = 0; k < 48; k++) begin
            exp = sb.pop_front();
            act = {A, B, C, D, EN, DIG, frame_done};
            vectors++;
            if (act !== exp) begin
                miscompares++;
                $display("FAIL lzb cyc %0d: got nib=%h en=%b dig=%b fd=%b want nib=%h en=%b dig=%b fd=%b",
                         k, act[9:6], act[5], act[4:1], act[0], exp[9:6], exp[5], exp[4:1], exp[0]);
            end
            load = (k == 0) || (k == 16);
            bcd_in = (k == 0) ? 16'h0070 : 16'h0000;
            if (load) $display("lzb: load %h", bcd_in);
            @(negedge clk);
        end
    endtask

    task automatic test_last_wins();
        logic [9:0] exp, act;
        lzb_en = 1'b0;
        push_frame(16'h0000, 4'b0000);
        push_frame(16'h2222, 4'b0000);
        for (int k = 0; k < 32; k++) begin
            exp = sb.pop_front();
            act = {A, B, C, D, EN, DIG, frame_done};
            vectors++;
            if (act !== exp) begin
                miscompares++;
                $display("FAIL last_wins cyc %0d: got nib=%h en=%b dig=%b fd=%b want nib=%h en=%b dig=%b fd=%b",
                         k, act[9:6], act[5], act[4:1], act[0], exp[9:6], exp[5], exp[4:1], exp[0]);
            end
            load = (k == 2) || (k == 9);
            bcd_in = (k == 2) ? 16'h1111 : 16'h2222;
            if (load) $display("last_wins: load %h", bcd_in);
            @(negedge clk);
        end
    endtask

    task automatic test_boundary_load();
        logic [9:0] exp, act;
        push_frame(16'h2222, 4'b0000);
        push_frame(16'h9999, 4'b0000);
        push_frame(16'h9999, 4'b0000);
        for (int k = 0; k < 48; k++) begin
            exp = sb.pop_front();
            act = {A, B, C, D, EN, DIG, frame_done};
            vectors++;
            if (act !== exp) begin
                miscompares++;
                $display("FAIL boundary_load cyc %0d: got nib=%h en=%b dig=%b fd=%b want nib=%h en=%b dig=%b fd=%b",
                         k, act[9:6], act[5], act[4:1], act[0], exp[9:6], exp[5], exp[4:1], exp[0]);
            end
            load = (k == 15); bcd_in = 16'h9999;
            if (load) $display("boundary_load: load 9999 in frame_done cycle");
            @(negedge clk);
        end
    endtask

    task automatic test_nonbcd();
        logic [9:0] exp, act;
        lzb_en = 1'b1;
        push_frame(16'h9999, 4'b0000);
        push_frame(16'h00A0, 4'b1100);
        for (int k = 0; k < 32; k++) begin
            exp = sb.pop_front();
            act = {A, B, C, D, EN, DIG, frame_done};
            vectors++;
            if (act !== exp) begin
                miscompares++;
                $display("FAIL nonbcd cyc %0d: got nib=%h en=%b dig=%b fd=%b want nib=%h en=%b dig=%b fd=%b",
                         k, act[9:6], act[5], act[4:1], act[0], exp[9:6], exp[5], exp[4:1], exp[0]);
            end
            load = (k == 3); bcd_in = 16'h00A0;
            if (load) $display("nonbcd: load 00A0");
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_update();
        test_lzb();
        test_last_wins();
        test_boundary_load();
        test_nonbcd();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bcd_scan_mux.md
Name: bcd_scan_mux

Overview:
- Upstream neighbour of the BCD-to-seven-segment decoder. Time-multiplexes NDIG BCD digits onto the decoder's single-digit inputs A, B, C, D and EN.
- Also drives a one-hot digit-select bus for a common-anode or common-cathode multi-digit display.
- Provides a prescaled scan rate, a blanking guard at each digit change (anti-ghosting), optional leading-zero blanking and tear-free value updates at frame boundaries.

Parameters:
- NDIG, 4: number of digits scanned; legal range 2..8.
- DIV, 1000: clock cycles per digit slot; must be at least GUARD+1.
- GUARD, 8: cycles at the start of each slot during which EN=0 and DIG=0; legal range 0..DIV-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load  in  1  single-cycle strobe; capture bcd_in.
- bcd_in  in  4*NDIG  packed digits; [3:0] is digit 0 (rightmost), [4*NDIG-1:4*NDIG-4] is the leftmost digit.
- lzb_en  in  1  level; 1 enables leading-zero blanking.
- A  out  1  MSB (bit 3) of the current digit nibble.
- B  out  1  bit 2 of the current digit nibble.
- C  out  1  bit 1 of the current digit nibble.
- D  out  1  LSB (bit 0) of the current digit nibble.
- EN  out  1  decoder enable; 0 blanks the segments.
- DIG  out  NDIG  one-hot digit select, active-high; bit i selects digit i.
- frame_done  out  1  one-cycle pulse when the last digit slot ends.

Behaviour:
- Clock and reset:
  - Single clock domain. rst_n is asynchronous active-low: assertion immediately clears all state; deassertion is synchronised by the integrator.
- Reset values:
  - cnt=0, idx=0, shadow=0, pend=0, pend_v=0.
  - A=B=C=D=0, EN=0, DIG=0, frame_done=0.
- Prescaler:
  - cnt counts 0..DIV-1.
  - At cnt==DIV-1, cnt wraps to 0 and idx advances.
  - idx wraps from NDIG-1 to 0. That edge is the frame boundary.
- Outputs:
  - All outputs are flops loaded from next-state, so they align with the current cnt/idx with no added latency and no glitches.
  - {A,B,C,D} = shadow nibble[idx] during the whole slot, including the guard.
  - During the guard (cnt < GUARD): EN=0 and DIG=0.
  - After the guard: DIG = 1<<idx, and EN = 1 unless the digit is blanked.
- Leading-zero blanking:
  - Digit i (i>0) is blanked when lzb_en=1 and nibbles i..NDIG-1 of shadow are all 0.
  - Digit 0 is never blanked.
  - A blanked digit still asserts DIG after the guard; only EN stays 0.
  - lzb_en is sampled live.
- Non-BCD nibbles (10..15):
  - Passed through unchanged; the decoder shows its error pattern.
  - They count as non-zero for blanking.
- Update protocol:
  - load captures bcd_in into pend and sets pend_v=1.
  - A second load before the boundary overwrites pend; last value wins.
  - At the frame boundary edge: if load is asserted on that edge, shadow <= bcd_in (bypass). Otherwise, if pend_v, shadow <= pend. pend_v clears either way.
  - Digits of the current frame never mix old and new values.
- frame_done: high for the single cycle in which idx==NDIG-1 and cnt==DIV-1.
- Reset mid-slot: outputs drop to their reset values immediately (asynchronous); scanning restarts at idx=0, cnt=0; any pending value is lost.
- Widths:
  - cnt is clog2(DIV) bits; idx is clog2(NDIG) bits.
  - Neither counter may overflow its range; the wrap compare is exact.

Decomposition:
- Shared package disp_pkg holds:
  - BCD_W=4;
  - the nibble-select function (packed word, index -> nibble);
  - the default NDIG/DIV/GUARD constants used by the display top.
- One sub-module, scan_prescaler: the cnt/idx counter pair with a wrap pulse and a guard flag.
- Blanking, the update protocol and the output flops stay in bcd_scan_mux.

Test Plan:
Bench configuration: NDIG=4, DIV=4, GUARD=1.
1. Reset and first frame: assert rst_n=0 mid-run -> immediately A..D=0, EN=0, DIG=0. Release -> idx 0..3 each last 4 cycles; per slot EN=0 and DIG=0 in cycle 0, EN=1 in cycles 1..3; frame_done pulses every 16 cycles.
2. Display update: load bcd_in=16'h1234 during idx=2 -> idx 2 and 3 still show 0. From the next boundary: slot 0 {A,B,C,D}=4'h4 with DIG=4'b0001; slot 1 3/0010; slot 2 2/0100; slot 3 1/1000.
3. Leading-zero blanking: lzb_en=1, value 16'h0070 -> EN=1 only in slots 0 and 1 (digits 0 and 7); slots 2 and 3 have EN=0 with DIG still asserted. Value 16'h0000 -> only slot 0 EN=1, showing 0.
4. Last value wins: loads 16'h1111 and then 16'h2222 within one frame -> next frame shows 2222 in every slot.
5. Load on the boundary: load 16'h9999 in the frame_done cycle -> the immediately following frame shows 9 in all slots.
6. Non-BCD passthrough: value 16'h00A0 with lzb_en=1 -> slot 1 {A,B,C,D}=4'hA with EN=1; slot 0 shows 0 with EN=1; slots 2 and 3 blanked.
